// File: rtl/l15_if.sv
// Transducer <-> L1.5 request/response bus.
interface l15_if;
   logic [4:0]  transducer_l15_rqtype;
   logic [2:0]  transducer_l15_size;
   logic [31:0] transducer_l15_address;
   logic [31:0] transducer_l15_data;
   logic        transducer_l15_val;
   logic        transducer_l15_req_ack;
   logic        l15_transducer_ack;
   logic        l15_transducer_header_ack;
   logic        l15_transducer_val;
   logic [63:0] l15_transducer_data_0;
   logic [63:0] l15_transducer_data_1;
   logic [3:0]  l15_transducer_returntype;

   // Core-side transducer issues requests and consumes responses.
   modport master (
      output transducer_l15_rqtype, transducer_l15_size, transducer_l15_address,
             transducer_l15_data, transducer_l15_val, transducer_l15_req_ack,
      input  l15_transducer_ack, l15_transducer_header_ack, l15_transducer_val,
             l15_transducer_data_0, l15_transducer_data_1, l15_transducer_returntype
   );

   // L1.5 side accepts requests and produces responses.
   modport slave (
      input  transducer_l15_rqtype, transducer_l15_size, transducer_l15_address,
             transducer_l15_data, transducer_l15_val, transducer_l15_req_ack,
      output l15_transducer_ack, l15_transducer_header_ack, l15_transducer_val,
             l15_transducer_data_0, l15_transducer_data_1, l15_transducer_returntype
   );
endinterface

// File: rtl/l15_responder.sv
// L1.5 cache stand-in: word memory, latency-delayed in-order responses, boot wake-up interrupt.
module l15_responder #(
   parameter int unsigned MEM_WORDS    = 256,
   parameter int unsigned LATENCY      = 2,
   parameter int unsigned WAKEUP_DELAY = 4,
   parameter int unsigned QDEPTH       = 2
) (
   input  logic                         clk,
   input  logic                         nrst,
   l15_if.slave                         bus,
   input  logic                         pl_we,
   input  logic [$clog2(MEM_WORDS)-1:0] pl_addr,
   input  logic [31:0]                  pl_data
);
   localparam int unsigned AW = $clog2(MEM_WORDS);
   localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int unsigned CW = $clog2(QDEPTH + 1);
   localparam int unsigned LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int unsigned DW = (WAKEUP_DELAY > 1) ? $clog2(WAKEUP_DELAY) : 1;

   typedef enum logic [1:0] {S_WAKE, S_INT, S_READY} state_t;
   typedef enum logic [1:0] {K_IFILL, K_LOAD, K_STORE, K_ERR} kind_t;

   state_t          state;
   logic [DW-1:0]   wake_cnt;
   logic            header_ack_r;
   logic            val_r;
   logic [63:0]     d0_r;
   logic [63:0]     d1_r;
   logic [3:0]      rt_r;

   logic [31:0]     mem [MEM_WORDS];

   kind_t           q_kind [QDEPTH];
   logic [AW-1:0]   q_idx  [QDEPTH];
   logic [LW-1:0]   q_cd   [QDEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_nxt;

   logic            accept;
   logic            pop;
   kind_t           req_kind;
   logic [AW-1:0]   req_idx;
   logic [PW-1:0]   cand_ptr;
   logic            cand_ok;
   logic            cand_due;
   logic [AW-1:0]   cand_idx;
   logic [AW-1:0]   cand_base;
   logic [63:0]     resp_d0;
   logic [63:0]     resp_d1;
   logic [3:0]      resp_rt;
   logic            ready_nxt;
   logic            unused_bits;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign bus.l15_transducer_header_ack = header_ack_r;
   assign bus.l15_transducer_val        = val_r;
   assign bus.l15_transducer_data_0     = d0_r;
   assign bus.l15_transducer_data_1     = d1_r;
   assign bus.l15_transducer_returntype = rt_r;

   // Size and byte-offset bits carry no meaning for word-only accesses.
   assign unused_bits = ^{bus.transducer_l15_size, bus.transducer_l15_address};

   assign accept    = bus.transducer_l15_val & header_ack_r;
   assign bus.l15_transducer_ack = accept;
   assign pop       = val_r & bus.transducer_l15_req_ack & (state == S_READY);
   assign req_idx   = bus.transducer_l15_address[2 +: AW];
   assign count_nxt = count + CW'(accept) - CW'(pop);
   assign ready_nxt = (state == S_READY) || ((state == S_INT) && bus.transducer_l15_req_ack);

   // Request type decode; anything unrecognised becomes an error response.
   always_comb begin
      case (bus.transducer_l15_rqtype)
         5'b10000: req_kind = K_IFILL;
         5'b00000: req_kind = K_LOAD;
         5'b00001: req_kind = K_STORE;
         default:  req_kind = K_ERR;
      endcase
   end

   // Pick the entry that would be presented after this edge: next head on a pop, else current head.
   always_comb begin
      cand_ptr = rd_ptr;
      cand_ok  = 1'b0;
      if (pop) begin
         cand_ptr = ptr_inc(rd_ptr);
         cand_ok  = (count > CW'(1));
      end else if (!val_r) begin
         cand_ok  = (count != '0);
      end
      cand_due = cand_ok && (q_cd[cand_ptr] == '0);
   end

   // Response payload, read from memory at presentation so earlier stores are visible.
   always_comb begin
      cand_idx  = q_idx[cand_ptr];
      cand_base = {cand_idx[AW-1:2], 2'b00};
      resp_d0   = '0;
      resp_d1   = '0;
      resp_rt   = 4'b1111;
      case (q_kind[cand_ptr])
         K_IFILL: begin
            resp_d0 = {mem[cand_base | AW'(1)], mem[cand_base]};
            resp_d1 = {mem[cand_base | AW'(3)], mem[cand_base | AW'(2)]};
            resp_rt = 4'b0001;
         end
         K_LOAD: begin
            resp_d0 = {32'b0, mem[cand_idx]};
            resp_rt = 4'b0000;
         end
         K_STORE: resp_rt = 4'b0100;
         default: resp_rt = 4'b1111;
      endcase
   end

   // Word memory; not reset so preloaded contents survive a reset. Store beats preload.
   always_ff @(posedge clk) begin
      if (pl_we) mem[pl_addr] <= pl_data;
      if (accept && (req_kind == K_STORE)) mem[req_idx] <= bus.transducer_l15_data;
   end

   // Control FSM, request queue and registered response outputs.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state        <= S_WAKE;
         wake_cnt     <= '0;
         header_ack_r <= 1'b0;
         val_r        <= 1'b0;
         d0_r         <= '0;
         d1_r         <= '0;
         rt_r         <= 4'b0000;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         for (int unsigned i = 0; i < QDEPTH; i++) begin
            q_kind[i] <= K_LOAD;
            q_idx[i]  <= '0;
            q_cd[i]   <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < QDEPTH; i++) begin
            if (q_cd[i] != '0) q_cd[i] <= q_cd[i] - LW'(1);
         end
         if (accept) begin
            q_kind[wr_ptr] <= req_kind;
            q_idx[wr_ptr]  <= req_idx;
            q_cd[wr_ptr]   <= LW'(LATENCY - 1);
            wr_ptr         <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         count        <= count_nxt;
         header_ack_r <= ready_nxt && (count_nxt != CW'(QDEPTH));

         case (state)
            S_WAKE: begin
               if (wake_cnt == DW'(WAKEUP_DELAY - 1)) begin
                  state <= S_INT;
                  val_r <= 1'b1;
                  d0_r  <= '0;
                  d1_r  <= '0;
                  rt_r  <= 4'b0111;
               end else begin
                  wake_cnt <= wake_cnt + DW'(1);
               end
            end
            S_INT: begin
               if (bus.transducer_l15_req_ack) begin
                  state <= S_READY;
                  val_r <= 1'b0;
                  rt_r  <= 4'b0000;
               end
            end
            S_READY: begin
               if (pop || !val_r) begin
                  val_r <= cand_due;
                  if (cand_due) begin
                     d0_r <= resp_d0;
                     d1_r <= resp_d1;
                     rt_r <= resp_rt;
                  end
               end
            end
            default: state <= S_WAKE;
         endcase
      end
   end
endmodule

// File: tb/tb_l15_responder.sv
// Directed bench for l15_responder with default parameters.
module tb_l15_responder;
   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_ADDI = 32'h00108093;
   localparam logic [31:0] I_LW   = 32'h0000A103;
   localparam logic [31:0] I_SW   = 32'h0020A023;

   logic       clk = 1'b0;
   logic       nrst;
   logic       pl_we;
   logic [7:0] pl_addr;
   logic [31:0] pl_data;
   int         checks = 0;
   int         errors = 0;

   l15_if bus();

   l15_responder dut (
      .clk     (clk),
      .nrst    (nrst),
      .bus     (bus),
      .pl_we   (pl_we),
      .pl_addr (pl_addr),
      .pl_data (pl_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Offer one request for one edge, checking it is accepted.
   task automatic req(input string tag, input logic [4:0] t, input logic [31:0] a, input logic [31:0] d);
      bus.transducer_l15_rqtype  = t;
      bus.transducer_l15_address = a;
      bus.transducer_l15_data    = d;
      bus.transducer_l15_val     = 1'b1;
      #1;
      chk({tag, " ack"}, 64'(bus.l15_transducer_ack), 64'd1);
      tick();
      bus.transducer_l15_val = 1'b0;
   endtask

   // Wait (bounded) for a response, check it, then consume it.
   task automatic wait_resp(input string tag, input logic [3:0] rt, input logic [63:0] d0, input logic [63:0] d1);
      int n = 0;
      while (!bus.l15_transducer_val && n < 20) begin
         tick();
         n++;
      end
      chk({tag, " val"}, 64'(bus.l15_transducer_val), 64'd1);
      chk({tag, " rt"}, 64'(bus.l15_transducer_returntype), 64'(rt));
      chk({tag, " d0"}, bus.l15_transducer_data_0, d0);
      chk({tag, " d1"}, bus.l15_transducer_data_1, d1);
      bus.transducer_l15_req_ack = 1'b1;
      tick();
      bus.transducer_l15_req_ack = 1'b0;
   endtask

   task automatic wake_check(input string tag);
      for (int i = 0; i < 3; i++) tick();
      chk({tag, " val before delay"}, 64'(bus.l15_transducer_val), 64'd0);
      tick();
      chk({tag, " int val"}, 64'(bus.l15_transducer_val), 64'd1);
      chk({tag, " int rt"}, 64'(bus.l15_transducer_returntype), 64'h7);
      chk({tag, " int d0"}, bus.l15_transducer_data_0, 64'd0);
   endtask

   initial begin
      nrst = 1'b0;
      pl_we = 1'b0; pl_addr = '0; pl_data = '0;
      bus.transducer_l15_rqtype  = 5'b00000;
      bus.transducer_l15_size    = 3'b010;
      bus.transducer_l15_address = '0;
      bus.transducer_l15_data    = '0;
      bus.transducer_l15_val     = 1'b1;
      bus.transducer_l15_req_ack = 1'b0;

      // Reset state, with preload running during reset.
      tick();
      chk("reset val", 64'(bus.l15_transducer_val), 64'd0);
      chk("reset rt", 64'(bus.l15_transducer_returntype), 64'd0);
      chk("reset header_ack", 64'(bus.l15_transducer_header_ack), 64'd0);
      chk("reset ack", 64'(bus.l15_transducer_ack), 64'd0);
      chk("reset d0", bus.l15_transducer_data_0, 64'd0);
      chk("reset d1", bus.l15_transducer_data_1, 64'd0);
      bus.transducer_l15_val = 1'b0;
      pl_we = 1'b1;
      pl_addr = 8'd0; pl_data = I_ADD;  tick();
      pl_addr = 8'd1; pl_data = I_ADDI; tick();
      pl_addr = 8'd2; pl_data = I_LW;   tick();
      pl_addr = 8'd3; pl_data = I_SW;   tick();
      pl_we = 1'b0;

      // Wake-up interrupt held until acknowledged.
      nrst = 1'b1;
      wake_check("wake");
      for (int i = 0; i < 5; i++) tick();
      chk("int held val", 64'(bus.l15_transducer_val), 64'd1);
      chk("int held header_ack", 64'(bus.l15_transducer_header_ack), 64'd0);
      bus.transducer_l15_req_ack = 1'b1;
      tick();
      bus.transducer_l15_req_ack = 1'b0;
      chk("int ack val", 64'(bus.l15_transducer_val), 64'd0);
      chk("int ack header_ack", 64'(bus.l15_transducer_header_ack), 64'd1);

      // Instruction fill, exact latency.
      req("imiss", 5'b10000, 32'h8, 32'h0);
      chk("imiss val t", 64'(bus.l15_transducer_val), 64'd0);
      tick();
      chk("imiss val t+1", 64'(bus.l15_transducer_val), 64'd0);
      tick();
      chk("imiss val t+2", 64'(bus.l15_transducer_val), 64'd1);
      chk("imiss rt", 64'(bus.l15_transducer_returntype), 64'h1);
      chk("imiss d0", bus.l15_transducer_data_0, {I_ADDI, I_ADD});
      chk("imiss d1", bus.l15_transducer_data_1, {I_SW, I_LW});
      bus.transducer_l15_req_ack = 1'b1;
      tick();
      bus.transducer_l15_req_ack = 1'b0;
      chk("imiss pop val", 64'(bus.l15_transducer_val), 64'd0);

      // Store then load back-to-back, responses back-to-back.
      req("st10", 5'b00001, 32'h0, 32'd10);
      chk("st10 header_ack", 64'(bus.l15_transducer_header_ack), 64'd1);
      req("ld0", 5'b00000, 32'h0, 32'h0);
      chk("b2b val early", 64'(bus.l15_transducer_val), 64'd0);
      tick();
      chk("b2b st val", 64'(bus.l15_transducer_val), 64'd1);
      chk("b2b st rt", 64'(bus.l15_transducer_returntype), 64'h4);
      chk("b2b st d0", bus.l15_transducer_data_0, 64'd0);
      bus.transducer_l15_req_ack = 1'b1;
      tick();
      chk("b2b ld val", 64'(bus.l15_transducer_val), 64'd1);
      chk("b2b ld rt", 64'(bus.l15_transducer_returntype), 64'h0);
      chk("b2b ld d0", bus.l15_transducer_data_0, 64'h0000_0000_0000_000A);
      chk("b2b ld d1", bus.l15_transducer_data_1, 64'd0);
      tick();
      bus.transducer_l15_req_ack = 1'b0;
      chk("b2b empty val", 64'(bus.l15_transducer_val), 64'd0);

      // Backpressure with a full queue.
      req("bp1", 5'b00000, 32'h4, 32'h0);
      req("bp2", 5'b00000, 32'h8, 32'h0);
      bus.transducer_l15_address = 32'hC;
      bus.transducer_l15_val = 1'b1;
      #1;
      chk("bp full header_ack", 64'(bus.l15_transducer_header_ack), 64'd0);
      chk("bp full ack", 64'(bus.l15_transducer_ack), 64'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("bp stall ack", 64'(bus.l15_transducer_ack), 64'd0);
         chk("bp stall val", 64'(bus.l15_transducer_val), 64'd1);
         chk("bp stall d0", bus.l15_transducer_data_0, {32'b0, I_ADDI});
      end
      bus.transducer_l15_req_ack = 1'b1;
      tick();
      bus.transducer_l15_req_ack = 1'b0;
      chk("bp pop header_ack", 64'(bus.l15_transducer_header_ack), 64'd1);
      chk("bp pop ack", 64'(bus.l15_transducer_ack), 64'd1);
      chk("bp pop val", 64'(bus.l15_transducer_val), 64'd1);
      chk("bp pop d0", bus.l15_transducer_data_0, {32'b0, I_LW});
      tick();
      bus.transducer_l15_val = 1'b0;
      chk("bp third accepted", 64'(bus.l15_transducer_header_ack), 64'd0);
      chk("bp hold d0", bus.l15_transducer_data_0, {32'b0, I_LW});
      bus.transducer_l15_req_ack = 1'b1;
      tick();
      chk("bp gap val", 64'(bus.l15_transducer_val), 64'd0);
      tick();
      chk("bp third val", 64'(bus.l15_transducer_val), 64'd1);
      chk("bp third d0", bus.l15_transducer_data_0, {32'b0, I_SW});
      tick();
      bus.transducer_l15_req_ack = 1'b0;
      chk("bp empty val", 64'(bus.l15_transducer_val), 64'd0);

      // Address wrap and error responses.
      req("wrap st", 5'b00001, 32'h400, 32'h5);
      req("wrap ld", 5'b00000, 32'h0, 32'h0);
      wait_resp("wrap st", 4'h4, 64'd0, 64'd0);
      wait_resp("wrap ld", 4'h0, 64'h5, 64'd0);
      req("err", 5'b00111, 32'h0, 32'hDEAD_BEEF);
      wait_resp("err", 4'hF, 64'd0, 64'd0);
      req("post err ld", 5'b00000, 32'h0, 32'h0);
      wait_resp("post err ld", 4'h0, 64'h5, 64'd0);

      // Reset while a response is pending.
      req("rst ld", 5'b00000, 32'h4, 32'h0);
      for (int n = 0; n < 20 && !bus.l15_transducer_val; n++) tick();
      chk("rst pre val", 64'(bus.l15_transducer_val), 64'd1);
      nrst = 1'b0;
      #1;
      chk("rst async val", 64'(bus.l15_transducer_val), 64'd0);
      chk("rst async d0", bus.l15_transducer_data_0, 64'd0);
      chk("rst async rt", 64'(bus.l15_transducer_returntype), 64'd0);
      chk("rst async header_ack", 64'(bus.l15_transducer_header_ack), 64'd0);
      tick();
      tick();
      nrst = 1'b1;
      wake_check("rewake");
      bus.transducer_l15_req_ack = 1'b1;
      tick();
      bus.transducer_l15_req_ack = 1'b0;
      chk("rewake header_ack", 64'(bus.l15_transducer_header_ack), 64'd1);
      req("retain imiss", 5'b10000, 32'h0, 32'h0);
      wait_resp("retain imiss", 4'h1, {I_ADDI, 32'h5}, {I_SW, I_LW});
      req("retain ld", 5'b00000, 32'hC, 32'h0);
      wait_resp("retain ld", 4'h0, {32'b0, I_SW}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/l15_responder.md
# l15_responder

Synthesizable parametrised model of the OpenPiton L1.5 cache as seen from the core's transducer port. It answers instruction-fill, load and store requests from a local word memory with configurable latency and a bounded number of outstanding requests. After reset it issues the wake-up interrupt, so a `core` instance boots with no hand-written stimulus. It sits outside `core` in simulation and FPGA bring-up, wired directly to the transducer request and response ports.

## Interface

Parameters:
- MEM_WORDS, 256: memory depth in 32-bit words; power of two, ≥ 4.
- LATENCY, 2: cycles from request accept to earliest response; ≥ 1.
- WAKEUP_DELAY, 4: cycles after reset release before the wake-up interrupt; ≥ 1.
- QDEPTH, 2: maximum outstanding requests; ≥ 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- transducer_l15_rqtype  in  5  request type: 5'b10000 IMISS, 5'b00000 LOAD, 5'b00001 STORE.
- transducer_l15_size  in  3  ignored; every access is treated as one 32-bit word.
- transducer_l15_address  in  32  byte address.
- transducer_l15_data  in  32  store data.
- transducer_l15_val  in  1  request valid.
- l15_transducer_ack  out  1  request accepted this cycle (combinational).
- l15_transducer_header_ack  out  1  ready for requests (registered).
- l15_transducer_val  out  1  response valid.
- l15_transducer_data_0  out  64  response data, low half.
- l15_transducer_data_1  out  64  response data, high half.
- l15_transducer_returntype  out  4  response type: 4'b0001 IFILL, 4'b0000 LOAD, 4'b0100 ST_ACK, 4'b0111 INT (wake-up), 4'b1111 ERR.
- transducer_l15_req_ack  in  1  core consumed the response.
- pl_we  in  1  preload write enable; works in any state.
- pl_addr  in  $clog2(MEM_WORDS)  preload word index.
- pl_data  in  32  preload data.

## Operation

- FSM states:
  - WAKE: counts WAKEUP_DELAY cycles, then moves to INT.
  - INT: drives val=1 and returntype=0111 with data=0; on req_ack moves to READY.
  - READY: normal request and response service.
- l15_transducer_header_ack = 1 only in READY with the queue not full.
- l15_transducer_ack = transducer_l15_val & header_ack. A request is accepted on any edge where ack=1.
- Word index w = address[2 +: log2(MEM_WORDS)]. The address wraps modulo MEM_WORDS. address[1:0] is ignored.
- STORE: mem[w] is written at the accept edge. The response is ST_ACK with data_0 = data_1 = 0.
- LOAD: data_0 = {32'b0, mem[w]}, data_1 = 0, returntype LOAD.
- IMISS: base b = w with bits [1:0] cleared. Response is data_0 = {mem[b+1], mem[b]}, data_1 = {mem[b+3], mem[b+2]}, returntype IFILL.
- Unknown rqtype: accepted, no memory write, response ERR with zero data.
- Load and IMISS data is read when the entry is presented at the queue head, so a store ahead of it in the queue is visible.
- Preload write and a STORE to the same word on the same edge: the STORE wins.
- Queue: in-order FIFO of QDEPTH entries. Each entry holds type, word index and a countdown loaded with LATENCY−1 at accept, decrementing each cycle and saturating at 0.
- Response: presented when the head countdown is 0. val, data and returntype are held stable until req_ack; the entry pops on val & req_ack.
- Accept and pop on the same edge are both honoured. Full is computed from the registered count, with no bypass.
- Reset, including mid-operation: the queue empties, the FSM returns to WAKE and all outputs go to 0. Memory contents are retained.

## Timing

- Reset values: every output is 0; returntype = 4'b0000.
- Wake-up: val=1 is first visible in the cycle after the WAKEUP_DELAY-th rising edge following nrst deassertion.
- Request latency: with an empty queue, accept at edge t makes val=1 visible after edge t+LATENCY.
- Back-to-back: if the next head is due, new data is visible immediately after the pop edge and val stays 1. Otherwise val=0 for at least one cycle.
- Throughput: one accept and one response per cycle at steady state.

## Test plan

- Wake-up: WAKEUP_DELAY=4, hold req_ack=0 → val=1, returntype=0111, header_ack=0 held indefinitely; pulse req_ack → val=0 and header_ack=1 on the next cycle.
- Instruction fill: preload mem[0..3] = ADD, ADDI, LW, SW; IMISS to address 0x8 → after 2 cycles returntype=0001, data_0={ADDI,ADD}, data_1={SW,LW}.
- Store then load: STORE addr 0x0 data 32'd10, then LOAD addr 0x0 back-to-back → ST_ACK, then LOAD with data_0=64'h0000_0000_0000_000A.
- Backpressure: QDEPTH=2, req_ack=0, three LOADs offered → two accepted; third ack=0 and header_ack=0 until the first pop; response data stable throughout.
- Wrap and ERR: MEM_WORDS=256, STORE 0x400 data 32'h5, LOAD 0x0 → data_0=64'h5; rqtype 5'b00111 → returntype=1111, data 0.
- Reset mid-response: assert nrst low while val=1 → all outputs 0 asynchronously; after release the wake-up INT recurs and the earlier preload data reads back unchanged.
